// File: rtl/video_pkg.sv
// video_pkg: screen geometry shared by the plotting controller, line drawer and framebuffer writer
//   HOR_ACTIVE_PIXELS / VER_ACTIVE_PIXELS : active screen size
//   X_WIDTH / Y_WIDTH                     : coordinate widths derived from the screen size
package video_pkg;
    localparam int HOR_ACTIVE_PIXELS = 640;
    localparam int VER_ACTIVE_PIXELS = 480;
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
endpackage

// File: rtl/line_drawer_step.sv
// line_drawer_step: one combinational Bresenham step
//   i_err, i_dx, i_dy : error term, |dx| and -|dy| (signed, W bits)
//   i_x, i_y          : current point
//   i_sx, i_sy        : 1 = step in the negative direction
//   o_err, o_x, o_y   : point and error term after the step
module line_drawer_step #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int W  = 13
) (
    input  logic signed [W-1:0]  i_err,
    input  logic signed [W-1:0]  i_dx,
    input  logic signed [W-1:0]  i_dy,
    input  logic        [XW-1:0] i_x,
    input  logic        [YW-1:0] i_y,
    input  logic                 i_sx,
    input  logic                 i_sy,
    output logic signed [W-1:0]  o_err,
    output logic        [XW-1:0] o_x,
    output logic        [YW-1:0] o_y
);
    logic signed [W-1:0] w_e2;
    logic                w_step_x;
    logic                w_step_y;
    always_comb begin
        w_e2     = i_err <<< 1;
        w_step_x = w_e2 >= i_dy;
        w_step_y = w_e2 <= i_dx;
        // both decisions use the pre-step error, so a diagonal step adds dy and dx together
        o_err    = i_err + (w_step_x ? i_dy : {W{1'b0}}) + (w_step_y ? i_dx : {W{1'b0}});
        o_x      = w_step_x ? (i_sx ? i_x - 1'b1 : i_x + 1'b1) : i_x;
        o_y      = w_step_y ? (i_sy ? i_y - 1'b1 : i_y + 1'b1) : i_y;
    end
endmodule

// File: rtl/line_drawer.sv
// line_drawer: Bresenham line rasteriser with a start/ready request side and a valid/ready pixel stream
//   clk, rst                 : clock, asynchronous active-high reset
//   start, ready             : segment request, accepted while ready=1
//   x1, y1, x2, y2           : segment endpoints, latched on start
//   pixel_x, pixel_y         : current pixel (registered)
//   pixel_valid, pixel_ready : pixel handshake towards the framebuffer writer
module line_drawer #(
    parameter  int HOR_ACTIVE_PIXELS = video_pkg::HOR_ACTIVE_PIXELS,
    parameter  int VER_ACTIVE_PIXELS = video_pkg::VER_ACTIVE_PIXELS,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready
);
    // three guard bits keep 2*err in range for any coordinates of the chosen widths
    localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 3;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;
    state_t              r_state;
    state_t              w_next;
    logic [X_WIDTH-1:0]  r_x1;
    logic [X_WIDTH-1:0]  r_x2;
    logic [X_WIDTH-1:0]  r_x;
    logic [Y_WIDTH-1:0]  r_y1;
    logic [Y_WIDTH-1:0]  r_y2;
    logic [Y_WIDTH-1:0]  r_y;
    logic signed [W-1:0] r_dx;
    logic signed [W-1:0] r_dy;
    logic signed [W-1:0] r_err;
    logic                r_sx;
    logic                r_sy;
    logic signed [W-1:0] w_dxs;
    logic signed [W-1:0] w_dys;
    logic signed [W-1:0] w_dx;
    logic signed [W-1:0] w_dy;
    logic signed [W-1:0] w_err;
    logic [X_WIDTH-1:0]  w_x;
    logic [Y_WIDTH-1:0]  w_y;
    logic                w_beat;
    logic                w_end;
    line_drawer_step #(.XW(X_WIDTH), .YW(Y_WIDTH), .W(W)) u_step (
        .i_err(r_err),
        .i_dx (r_dx),
        .i_dy (r_dy),
        .i_x  (r_x),
        .i_y  (r_y),
        .i_sx (r_sx),
        .i_sy (r_sy),
        .o_err(w_err),
        .o_x  (w_x),
        .o_y  (w_y)
    );
    always_comb begin
        w_dxs  = $signed({{(W-X_WIDTH){1'b0}}, r_x2}) - $signed({{(W-X_WIDTH){1'b0}}, r_x1});
        w_dys  = $signed({{(W-Y_WIDTH){1'b0}}, r_y2}) - $signed({{(W-Y_WIDTH){1'b0}}, r_y1});
        w_dx   = (w_dxs < 0) ? -w_dxs : w_dxs;
        w_dy   = (w_dys < 0) ? w_dys : -w_dys;
        w_beat = (r_state == S_DRAW) && pixel_ready;
        w_end  = (r_x == r_x2) && (r_y == r_y2);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == S_IDLE)  ? (start ? S_SETUP : S_IDLE) :
                 (r_state == S_SETUP) ? S_DRAW :
                 (r_state == S_DRAW && !(w_beat && w_end)) ? S_DRAW : S_IDLE;
    end
    always_comb begin
        ready       = r_state == S_IDLE;
        pixel_valid = r_state == S_DRAW;
        pixel_x     = r_x;
        pixel_y     = r_y;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1  <= '0;
            r_x2  <= '0;
            r_y1  <= '0;
            r_y2  <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_dx  <= '0;
            r_dy  <= '0;
            r_err <= '0;
            r_sx  <= 1'b0;
            r_sy  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_x1 <= x1;
            r_y1 <= y1;
            r_x2 <= x2;
            r_y2 <= y2;
        end else if (r_state == S_SETUP) begin
            r_dx  <= w_dx;
            r_dy  <= w_dy;
            r_err <= w_dx + w_dy;
            r_sx  <= !(r_x1 < r_x2);
            r_sy  <= !(r_y1 < r_y2);
            r_x   <= r_x1;
            r_y   <= r_y1;
        end else if (w_beat && !w_end) begin
            r_err <= w_err;
            r_x   <= w_x;
            r_y   <= w_y;
        end
    end
endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer: directed and randomised segments checked against a Bresenham reference model
module tb_line_drawer;
    import video_pkg::*;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               ready;
    logic [X_WIDTH-1:0] x1, x2, pixel_x;
    logic [Y_WIDTH-1:0] y1, y2, pixel_y;
    logic               pixel_valid;
    logic               pixel_ready;
    int                 tests = 0;
    int                 fails = 0;
    int                 qx[$];
    int                 qy[$];
    int                 cx, cy, nx, ny;

    always #5 clk = ~clk;

    line_drawer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference pixel list straight from the textbook integer Bresenham formulation
    function automatic void model(input int ax1, input int ay1, input int ax2, input int ay2);
        int dx, dy, sx, sy, err, e2, x, y;
        qx.delete();
        qy.delete();
        dx  = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
        dy  = -((ay2 > ay1) ? ay2 - ay1 : ay1 - ay2);
        sx  = (ax1 < ax2) ? 1 : -1;
        sy  = (ay1 < ay2) ? 1 : -1;
        err = dx + dy;
        x   = ax1;
        y   = ay1;
        while (1) begin
            qx.push_back(x);
            qy.push_back(y);
            if (x == ax2 && y == ay2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    task automatic seg(input int ax1, input int ay1, input int ax2, input int ay2, input bit bp, input bit poke);
        int  n, got, j, hx, hy, adx, ady;
        bit  stall;
        model(ax1, ay1, ax2, ay2);
        n   = qx.size();
        adx = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
        ady = (ay2 > ay1) ? ay2 - ay1 : ay1 - ay2;
        @(negedge clk);
        x1 = X_WIDTH'(ax1);
        y1 = Y_WIDTH'(ay1);
        x2 = X_WIDTH'(ax2);
        y2 = Y_WIDTH'(ay2);
        start = 1'b1;
        pixel_ready = bp ? 1'($urandom) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        x1 = X_WIDTH'($urandom);
        y1 = Y_WIDTH'($urandom);
        x2 = X_WIDTH'($urandom);
        y2 = Y_WIDTH'($urandom);
        check("ready_after_start", ready, 0);
        check("setup_no_valid", pixel_valid, 0);
        got   = 0;
        j     = 0;
        stall = 1'b0;
        hx    = 0;
        hy    = 0;
        while (j < 4000) begin
            @(negedge clk);
            j++;
            if (ready) break;
            if (j == 1) check("ready_poll", ready, 0);
            check("valid_in_draw", pixel_valid, 1);
            if (stall) begin
                check("hold_x", pixel_x, hx);
                check("hold_y", pixel_y, hy);
            end
            start = poke && got == 2;
            if (start) begin
                x1 = X_WIDTH'($urandom);
                y1 = Y_WIDTH'($urandom);
                x2 = X_WIDTH'($urandom);
                y2 = Y_WIDTH'($urandom);
            end
            pixel_ready = bp ? 1'($urandom) : 1'b1;
            if (pixel_valid && pixel_ready) begin
                check("pixel_x", pixel_x, (got < n) ? qx[got] : -1);
                check("pixel_y", pixel_y, (got < n) ? qy[got] : -1);
                got++;
                stall = 1'b0;
            end else begin
                stall = pixel_valid;
                hx    = pixel_x;
                hy    = pixel_y;
            end
        end
        start = 1'b0;
        check("ready_returns", j < 4000, 1);
        check("pixel_count", got, ((adx > ady) ? adx : ady) + 1);
        check("idle_no_valid", pixel_valid, 0);
        if (!bp) check("busy_cycles", j, n + 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pixel_ready = 1'b0;
        x1 = '0;
        y1 = '0;
        x2 = '0;
        y2 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_valid", pixel_valid, 0);
        check("rst_px", pixel_x, 0);
        check("rst_py", pixel_y, 0);
        rst = 1'b0;
        seg(0, 240, 7, 240, 0, 0);
        seg(10, 10, 12, 15, 0, 0);
        seg(7, 5, 0, 2, 0, 0);
        seg(3, 3, 3, 3, 0, 0);
        repeat (4) seg(10, 10, 12, 15, 1, 0);
        seg(0, 0, 40, 25, 0, 1);
        seg(50, 60, 5, 70, 1, 1);
        seg(1020, 500, 1023, 511, 0, 0);
        seg(639, 0, 600, 479, 1, 0);
        @(negedge clk);
        x1 = '0;
        y1 = '0;
        x2 = X_WIDTH'(99);
        y2 = '0;
        start = 1'b1;
        pixel_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_px", pixel_x, 3);
        check("pre_rst_valid", pixel_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", pixel_valid, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_px", pixel_x, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", pixel_valid, 0);
        seg(0, 0, 1, 1, 0, 0);
        cx = 20;
        cy = 20;
        for (int i = 0; i < 79; i++) begin
            nx = $urandom_range(0, 127);
            ny = $urandom_range(0, 127);
            seg(cx, cy, nx, ny, i % 3 == 0, i % 5 == 0);
            cx = nx;
            cy = ny;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
